uniform_coeff_sampler: RTL and testbench

- Consumer and initiator for the 16-bit PRNG word interface (start/done/prng_gen); requests one word at a time from prng_16bit.
- Converts PRNG words into uniform coefficients in [0, Q) by masking and rejection.
- Emits N_COEFF coefficients per batch over a valid/ready stream to the polynomial memory writer in the FHE datapath.

---
 rtl/uniform_coeff_sampler.sv | 144 ++++++++++++++
 tb/tb_uniform_coeff_sampler.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uniform_coeff_sampler.sv
// Uniform coefficient sampler: pulls 16-bit PRNG words one at a time, masks them to
// MASK_BITS, rejects values >= Q and streams N_COEFF accepted coefficients per batch.
module uniform_coeff_sampler #(
  parameter int Q         = 12289,
  parameter int MASK_BITS = 14,
  parameter int N_COEFF   = 256,
  parameter int IDX_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             req,
  output logic             prng_start,
  input  logic             prng_done,
  input  logic [15:0]      prng_data,
  output logic [15:0]      coeff_out,
  output logic             coeff_valid,
  input  logic             coeff_ready,
  output logic [IDX_W-1:0] coeff_idx,
  output logic             busy,
  output logic             batch_done,
  output logic [15:0]      reject_cnt
);

  typedef enum logic [2:0] {IDLE, REQ, CHECK, OUT, DONE} state_t;

  // One extra bit so that Q == 2^MASK_BITS is representable in the comparison.
  localparam logic [MASK_BITS:0]   Q_L      = (MASK_BITS + 1)'(Q);
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(N_COEFF - 1);

  state_t                 state_q, state_d;
  logic                   prng_start_q, prng_start_d;
  logic [MASK_BITS-1:0]   latched_q, latched_d;
  logic [15:0]            coeff_out_q, coeff_out_d;
  logic                   coeff_valid_q, coeff_valid_d;
  logic [IDX_W-1:0]       coeff_idx_q, coeff_idx_d;
  logic                   busy_q, busy_d;
  logic                   batch_done_q, batch_done_d;
  logic [15:0]            reject_cnt_q, reject_cnt_d;
  logic                   accept;
  logic                   prng_hi_unused;

  assign prng_hi_unused = ^prng_data[15:MASK_BITS];
  assign accept         = ({1'b0, latched_q} < Q_L);

  always_comb begin
    state_d       = state_q;
    prng_start_d  = prng_start_q;
    latched_d     = latched_q;
    coeff_out_d   = coeff_out_q;
    coeff_valid_d = coeff_valid_q;
    coeff_idx_d   = coeff_idx_q;
    batch_done_d  = batch_done_q;
    reject_cnt_d  = reject_cnt_q;
    // With en low nothing advances; every register simply holds.
    if (en) begin
      batch_done_d = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req) begin
            state_d      = REQ;
            prng_start_d = 1'b1;
            coeff_idx_d  = '0;
            reject_cnt_d = '0;
          end
        end
        REQ: begin
          if (prng_done) begin
            latched_d    = prng_data[MASK_BITS-1:0];
            state_d      = CHECK;
            prng_start_d = 1'b0;
          end
        end
        CHECK: begin
          if (accept) begin
            state_d       = OUT;
            coeff_out_d   = 16'(latched_q);
            coeff_valid_d = 1'b1;
          end else begin
            if (reject_cnt_q != 16'hFFFF) begin
              reject_cnt_d = reject_cnt_q + 16'd1;
            end
            state_d      = REQ;
            prng_start_d = 1'b1;
          end
        end
        OUT: begin
          if (coeff_ready) begin
            coeff_valid_d = 1'b0;
            if (coeff_idx_q == LAST_IDX) begin
              state_d      = DONE;
              batch_done_d = 1'b1;
            end else begin
              coeff_idx_d  = coeff_idx_q + IDX_W'(1);
              state_d      = REQ;
              prng_start_d = 1'b1;
            end
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      prng_start_q  <= 1'b0;
      latched_q     <= '0;
      coeff_out_q   <= '0;
      coeff_valid_q <= 1'b0;
      coeff_idx_q   <= '0;
      busy_q        <= 1'b0;
      batch_done_q  <= 1'b0;
      reject_cnt_q  <= '0;
    end else begin
      state_q       <= state_d;
      prng_start_q  <= prng_start_d;
      latched_q     <= latched_d;
      coeff_out_q   <= coeff_out_d;
      coeff_valid_q <= coeff_valid_d;
      coeff_idx_q   <= coeff_idx_d;
      busy_q        <= busy_d;
      batch_done_q  <= batch_done_d;
      reject_cnt_q  <= reject_cnt_d;
    end
  end

  // The request level is suppressed while the block is frozen.
  assign prng_start  = prng_start_q & en;
  assign coeff_out   = coeff_out_q;
  assign coeff_valid = coeff_valid_q;
  assign coeff_idx   = coeff_idx_q;
  assign busy        = busy_q;
  assign batch_done  = batch_done_q;
  assign reject_cnt  = reject_cnt_q;

endmodule

// File: tb/tb_uniform_coeff_sampler.sv
// Directed bench for uniform_coeff_sampler with a 4-coefficient batch.
module tb_uniform_coeff_sampler;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        req;
  logic        prng_start;
  logic        prng_done;
  logic [15:0] prng_data;
  logic [15:0] coeff_out;
  logic        coeff_valid;
  logic        coeff_ready;
  logic [1:0]  coeff_idx;
  logic        busy;
  logic        batch_done;
  logic [15:0] reject_cnt;

  int n_checks;
  int n_fail;

  uniform_coeff_sampler #(
    .Q(12289), .MASK_BITS(14), .N_COEFF(4), .IDX_W(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .prng_start(prng_start), .prng_done(prng_done), .prng_data(prng_data),
    .coeff_out(coeff_out), .coeff_valid(coeff_valid), .coeff_ready(coeff_ready),
    .coeff_idx(coeff_idx), .busy(busy), .batch_done(batch_done), .reject_cnt(reject_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for prng_start, optionally lingers, then pulses prng_done with w.
  task automatic give_word(input logic [15:0] w, input int delay);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (prng_start === 1'b1) seen = 1'b1;
      else tick();
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("[TB] FAIL prng_start_timeout: got %b expected 1", prng_start);
    end
    repeat (delay) tick();
    prng_done = 1'b1;
    prng_data = w;
    tick();
    prng_done = 1'b0;
    prng_data = 16'hA5A5;
  endtask

  task automatic handshake();
    coeff_ready = 1'b1;
    tick();
    coeff_ready = 1'b0;
  endtask

  task automatic pulse_req();
    req = 1'b1;
    tick();
    req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_checks++;
    if ({prng_start, coeff_valid, busy, batch_done} !== 4'b0000) begin
      n_fail++;
      $display("[TB] FAIL reset_flags: got %b expected 0000", {prng_start, coeff_valid, busy, batch_done});
    end
    n_checks++;
    if (coeff_out !== 16'd0 || coeff_idx !== 2'd0 || reject_cnt !== 16'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_values: got out=%0d idx=%0d rej=%0d expected 0 0 0", coeff_out, coeff_idx, reject_cnt);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_accept();
    pulse_req();
    n_checks++;
    if (prng_start !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL accept_req_entry: got start=%b busy=%b expected 1 1", prng_start, busy);
    end
    give_word(16'h1234, 2);
    n_checks++;
    if (prng_start !== 1'b0 || coeff_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL accept_check_cycle: got start=%b valid=%b expected 0 0", prng_start, coeff_valid);
    end
    tick();
    n_checks++;
    if (coeff_valid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL accept_valid_latency: got %b expected 1", coeff_valid);
    end
    n_checks++;
    if (coeff_out !== 16'd4660) begin
      n_fail++;
      $display("[TB] FAIL accept_coeff_out: got %0d expected 4660", coeff_out);
    end
    n_checks++;
    if (coeff_idx !== 2'd0 || reject_cnt !== 16'd0) begin
      n_fail++;
      $display("[TB] FAIL accept_idx_rej: got idx=%0d rej=%0d expected 0 0", coeff_idx, reject_cnt);
    end
    handshake();
    n_checks++;
    if (coeff_valid !== 1'b0 || coeff_idx !== 2'd1 || prng_start !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL accept_after_hs: got valid=%b idx=%0d start=%b expected 0 1 1", coeff_valid, coeff_idx, prng_start);
    end
  endtask

  task automatic test_reject();
    give_word(16'h3001, 2);
    tick();
    n_checks++;
    if (prng_start !== 1'b1 || coeff_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reject_q_restart: got start=%b valid=%b expected 1 0", prng_start, coeff_valid);
    end
    n_checks++;
    if (reject_cnt !== 16'd1) begin
      n_fail++;
      $display("[TB] FAIL reject_q_count: got %0d expected 1", reject_cnt);
    end
    give_word(16'hF000, 0);
    tick();
    n_checks++;
    if (coeff_valid !== 1'b1 || coeff_out !== 16'd12288) begin
      n_fail++;
      $display("[TB] FAIL reject_masked_accept: got valid=%b out=%0d expected 1 12288", coeff_valid, coeff_out);
    end
    n_checks++;
    if (reject_cnt !== 16'd1 || coeff_idx !== 2'd1) begin
      n_fail++;
      $display("[TB] FAIL reject_masked_state: got rej=%0d idx=%0d expected 1 1", reject_cnt, coeff_idx);
    end
    handshake();
  endtask

  task automatic test_boundary();
    give_word(16'hFFFF, 0);
    tick();
    n_checks++;
    if (reject_cnt !== 16'd2 || prng_start !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL boundary_max_reject: got rej=%0d start=%b expected 2 1", reject_cnt, prng_start);
    end
    give_word(16'h7000, 0);
    tick();
    n_checks++;
    if (coeff_valid !== 1'b1 || coeff_out !== 16'd12288 || coeff_idx !== 2'd2) begin
      n_fail++;
      $display("[TB] FAIL boundary_q_minus_1: got valid=%b out=%0d idx=%0d expected 1 12288 2", coeff_valid, coeff_out, coeff_idx);
    end
    handshake();
  endtask

  task automatic test_stall_and_done();
    give_word(16'h4ABC, 1);
    tick();
    for (int i = 0; i < 5; i++) begin
      prng_done = (i == 2);
      prng_data = 16'h0001;
      tick();
      n_checks++;
      if (coeff_valid !== 1'b1 || coeff_out !== 16'd2748 || coeff_idx !== 2'd3 || prng_start !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL stall_hold[%0d]: got valid=%b out=%0d idx=%0d start=%b expected 1 2748 3 0",
                 i, coeff_valid, coeff_out, coeff_idx, prng_start);
      end
    end
    prng_done = 1'b0;
    handshake();
    n_checks++;
    if (batch_done !== 1'b1 || busy !== 1'b1 || coeff_valid !== 1'b0 || coeff_idx !== 2'd3) begin
      n_fail++;
      $display("[TB] FAIL done_pulse: got bd=%b busy=%b valid=%b idx=%0d expected 1 1 0 3", batch_done, busy, coeff_valid, coeff_idx);
    end
    tick();
    n_checks++;
    if (batch_done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL done_to_idle: got bd=%b busy=%b expected 0 0", batch_done, busy);
    end
    n_checks++;
    if (coeff_idx !== 2'd3 || reject_cnt !== 16'd2) begin
      n_fail++;
      $display("[TB] FAIL done_hold_counts: got idx=%0d rej=%0d expected 3 2", coeff_idx, reject_cnt);
    end
    tick();
    n_checks++;
    if (batch_done !== 1'b0 || prng_start !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL idle_quiet: got bd=%b start=%b expected 0 0", batch_done, prng_start);
    end
  endtask

  task automatic test_enable();
    pulse_req();
    n_checks++;
    if (coeff_idx !== 2'd0 || reject_cnt !== 16'd0 || prng_start !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL enable_new_batch: got idx=%0d rej=%0d start=%b expected 0 0 1", coeff_idx, reject_cnt, prng_start);
    end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      prng_done = 1'b1;
      prng_data = 16'h0007;
      tick();
      n_checks++;
      if (prng_start !== 1'b0 || coeff_valid !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL enable_frozen[%0d]: got start=%b valid=%b busy=%b expected 0 0 1", i, prng_start, coeff_valid, busy);
      end
    end
    prng_done = 1'b0;
    en = 1'b1;
    #1;
    n_checks++;
    if (prng_start !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL enable_resume_req: got %b expected 1", prng_start);
    end
    give_word(16'h0005, 0);
    tick();
    n_checks++;
    if (coeff_valid !== 1'b1 || coeff_out !== 16'd5 || coeff_idx !== 2'd0) begin
      n_fail++;
      $display("[TB] FAIL enable_word: got valid=%b out=%0d idx=%0d expected 1 5 0", coeff_valid, coeff_out, coeff_idx);
    end
    en = 1'b0;
    coeff_ready = 1'b1;
    tick();
    tick();
    n_checks++;
    if (coeff_valid !== 1'b1 || coeff_idx !== 2'd0) begin
      n_fail++;
      $display("[TB] FAIL enable_no_hs: got valid=%b idx=%0d expected 1 0", coeff_valid, coeff_idx);
    end
    en = 1'b1;
    tick();
    coeff_ready = 1'b0;
    n_checks++;
    if (coeff_valid !== 1'b0 || coeff_idx !== 2'd1) begin
      n_fail++;
      $display("[TB] FAIL enable_hs_resume: got valid=%b idx=%0d expected 0 1", coeff_valid, coeff_idx);
    end
  endtask

  task automatic test_reset_mid_batch();
    give_word(16'h0010, 0);
    tick();
    handshake();
    give_word(16'h0020, 0);
    tick();
    n_checks++;
    if (coeff_valid !== 1'b1 || coeff_idx !== 2'd2 || coeff_out !== 16'd32) begin
      n_fail++;
      $display("[TB] FAIL midrst_setup: got valid=%b idx=%0d out=%0d expected 1 2 32", coeff_valid, coeff_idx, coeff_out);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({prng_start, coeff_valid, busy, batch_done} !== 4'b0000 ||
        coeff_out !== 16'd0 || coeff_idx !== 2'd0 || reject_cnt !== 16'd0) begin
      n_fail++;
      $display("[TB] FAIL midrst_async: got flags=%b out=%0d idx=%0d rej=%0d expected 0000 0 0 0",
               {prng_start, coeff_valid, busy, batch_done}, coeff_out, coeff_idx, reject_cnt);
    end
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (busy !== 1'b0 || batch_done !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL midrst_idle: got busy=%b bd=%b expected 0 0", busy, batch_done);
    end
    pulse_req();
    n_checks++;
    if (coeff_idx !== 2'd0 || reject_cnt !== 16'd0 || prng_start !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL midrst_restart: got idx=%0d rej=%0d start=%b expected 0 0 1", coeff_idx, reject_cnt, prng_start);
    end
    give_word(16'hC123, 0);
    tick();
    n_checks++;
    if (coeff_valid !== 1'b1 || coeff_out !== 16'd291) begin
      n_fail++;
      $display("[TB] FAIL midrst_first_word: got valid=%b out=%0d expected 1 291", coeff_valid, coeff_out);
    end
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    en          = 1'b1;
    req         = 1'b0;
    prng_done   = 1'b0;
    prng_data   = 16'hA5A5;
    coeff_ready = 1'b0;
    $display("[TB] starting uniform_coeff_sampler bench");
    test_reset();
    test_accept();
    test_reject();
    test_boundary();
    test_stall_and_done();
    test_enable();
    test_reset_mid_batch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
